// File: rtl/pipe_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_if
//
// Purpose: bundles the hazard status coming from the pipeline datapath and the
// stage-register controls going back to it, so the sequencer and the datapath
// exchange one port instead of two dozen loose wires.
//
// Signals (datapath -> sequencer):
//   ihit          instruction fetch complete this cycle
//   dmem_req      EX/MEM holds a load or store
//   dhit          data access complete this cycle
//   idex_memread  ID/EX holds a load
//   idex_rt[4:0]  ID/EX load destination register
//   ifid_rs[4:0]  rs field of the IF/ID instruction
//   ifid_rt[4:0]  rt field of the IF/ID instruction
//   branch_taken  branch resolved taken in MEM
//   halt_mem      HALT opcode present in EX/MEM
// Signals (sequencer -> datapath):
//   pc_wen, {ifid,idex,exmem,memwb}_{wen,flush}, halted, mem_err
//   stall_cnt[31:0], flush_cnt[31:0]   only when HAZARD_PERF_EN is defined
//
// Modports: master = datapath side, slave = sequencer side.
// Optional feature macro: HAZARD_PERF_EN
// -----------------------------------------------------------------------------
interface pipe_hazard_ctrl_if;
    logic       ihit;
    logic       dmem_req;
    logic       dhit;
    logic       idex_memread;
    logic [4:0] idex_rt;
    logic [4:0] ifid_rs;
    logic [4:0] ifid_rt;
    logic       branch_taken;
    logic       halt_mem;

    logic       pc_wen;
    logic       ifid_wen;
    logic       ifid_flush;
    logic       idex_wen;
    logic       idex_flush;
    logic       exmem_wen;
    logic       exmem_flush;
    logic       memwb_wen;
    logic       memwb_flush;
    logic       halted;
    logic       mem_err;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    modport master (
        output ihit, dmem_req, dhit, idex_memread, idex_rt, ifid_rs, ifid_rt,
               branch_taken, halt_mem,
        input  pc_wen, ifid_wen, ifid_flush, idex_wen, idex_flush,
               exmem_wen, exmem_flush, memwb_wen, memwb_flush, halted, mem_err
`ifdef HAZARD_PERF_EN
        , input stall_cnt, flush_cnt
`endif
    );

    modport slave (
        input  ihit, dmem_req, dhit, idex_memread, idex_rt, ifid_rs, ifid_rt,
               branch_taken, halt_mem,
        output pc_wen, ifid_wen, ifid_flush, idex_wen, idex_flush,
               exmem_wen, exmem_flush, memwb_wen, memwb_flush, halted, mem_err
`ifdef HAZARD_PERF_EN
        , output stall_cnt, flush_cnt
`endif
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Purpose: central sequencer for the 5-stage pipeline register chain. Decides
// every cycle which stage registers load, which are cleared to a bubble, and
// whether the PC advances. Handles data-memory wait stalls (with a timeout
// flag), load-use hazards, taken-branch squashes, instruction-fetch misses and
// the drain/stop sequence after HALT reaches MEM.
//
// Ports:
//   CLK   system clock, all state on the rising edge
//   RST   synchronous, active-high reset
//   hz    pipe_hazard_ctrl_if.slave (hazard status in, stage controls out)
//
// Parameters:
//   DRAIN_CYCLES  cycles spent in DRAIN before HALTED (1..7)
//   MEM_TIMEOUT   consecutive data-wait cycles that raise mem_err (8-bit)
//
// Optional feature macro: HAZARD_PERF_EN
//   defined   -> hz.stall_cnt / hz.flush_cnt performance counters exist
//   undefined -> no counter logic
//
// Control outputs are combinational from state and inputs; only the state,
// the wait/drain counters, halted, mem_err and the optional counters are
// registered.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 2,
    parameter int unsigned MEM_TIMEOUT  = 255
) (
    input  logic              CLK,
    input  logic              RST,
    pipe_hazard_ctrl_if.slave hz
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DWAIT,
        ST_DRAIN,
        ST_HALTED
    } state_t;

    // One bit per control line; all-zero is the full-freeze pattern.
    typedef struct packed {
        logic pc_wen;
        logic ifid_wen;
        logic ifid_flush;
        logic idex_wen;
        logic idex_flush;
        logic exmem_wen;
        logic exmem_flush;
        logic memwb_wen;
        logic memwb_flush;
    } ctrl_t;

    localparam logic [7:0] TIMEOUT_LIM = 8'(MEM_TIMEOUT);
    localparam logic [2:0] DRAIN_LIM   = 3'(DRAIN_CYCLES);

    state_t     state_q, state_d;
    logic [7:0] tcnt_q,  tcnt_d;
    logic [2:0] dcnt_q,  dcnt_d;
    logic       halted_q, halted_d;
    logic       mem_err_q, mem_err_d;

    ctrl_t      run_ctrl;     // outcome of the RUN priority list, minus the memory-wait rule
    logic       run_halt;
    logic       run_branch;
    logic       load_use;
    ctrl_t      ctrl;
    logic       dfreeze;      // this cycle is a data-memory wait freeze
    logic       branch_sq;    // a taken-branch squash is issued this cycle

    // ------------------------------------------------------------------------
    // Priority resolution shared by RUN and the releasing DWAIT cycle.
    // Rule order: halt > branch > load-use > fetch miss > normal flow.
    // A load-use stall outranks a fetch miss so that the stalled instruction
    // in IF/ID is held rather than being flushed away.
    // ------------------------------------------------------------------------
    assign load_use = hz.idex_memread && (hz.idex_rt != 5'd0) &&
                      ((hz.idex_rt == hz.ifid_rs) || (hz.idex_rt == hz.ifid_rt));

    // NOTE: every signal written in an always_comb is given a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        run_ctrl   = '0;
        run_halt   = 1'b0;
        run_branch = 1'b0;
        if (hz.halt_mem) begin
            run_halt             = 1'b1;
            run_ctrl.ifid_flush  = 1'b1;
            run_ctrl.idex_flush  = 1'b1;
            run_ctrl.exmem_flush = 1'b1;
            run_ctrl.memwb_wen   = 1'b1;
        end else if (hz.branch_taken) begin
            run_branch           = 1'b1;
            run_ctrl.pc_wen      = 1'b1;
            run_ctrl.ifid_flush  = 1'b1;
            run_ctrl.idex_flush  = 1'b1;
            run_ctrl.exmem_flush = 1'b1;
            run_ctrl.memwb_wen   = 1'b1;
        end else if (load_use) begin
            // Hold PC and IF/ID, inject a bubble into ID/EX, let the rest move.
            run_ctrl.idex_flush  = 1'b1;
            run_ctrl.exmem_wen   = 1'b1;
            run_ctrl.memwb_wen   = 1'b1;
        end else if (!hz.ihit) begin
            // Fetch not back yet: bubble into IF/ID, downstream keeps flowing.
            run_ctrl.ifid_flush  = 1'b1;
            run_ctrl.idex_wen    = 1'b1;
            run_ctrl.exmem_wen   = 1'b1;
            run_ctrl.memwb_wen   = 1'b1;
        end else begin
            run_ctrl.pc_wen      = 1'b1;
            run_ctrl.ifid_wen    = 1'b1;
            run_ctrl.idex_wen    = 1'b1;
            run_ctrl.exmem_wen   = 1'b1;
            run_ctrl.memwb_wen   = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and control outputs.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        tcnt_d    = tcnt_q;
        dcnt_d    = dcnt_q;
        halted_d  = halted_q;
        mem_err_d = mem_err_q;
        ctrl      = '0;
        dfreeze   = 1'b0;
        branch_sq = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (hz.dmem_req && !hz.dhit) begin
                    dfreeze = 1'b1;
                    state_d = ST_DWAIT;
                    tcnt_d  = 8'd1;
                end else begin
                    ctrl      = run_ctrl;
                    branch_sq = run_branch;
                    if (run_halt) begin
                        state_d = ST_DRAIN;
                        dcnt_d  = 3'd1;
                    end
                end
            end

            ST_DWAIT: begin
                if (!hz.dhit) begin
                    dfreeze = 1'b1;
                    if (tcnt_q != 8'hFF) begin
                        tcnt_d = tcnt_q + 8'd1;
                    end
                end else begin
                    ctrl      = run_ctrl;
                    branch_sq = run_branch;
                    tcnt_d    = 8'd0;
                    if (run_halt) begin
                        state_d = ST_DRAIN;
                        dcnt_d  = 3'd1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end

            ST_DRAIN: begin
                // Front of the pipe is squashed while MEM/WB retires what is left.
                ctrl.ifid_flush  = 1'b1;
                ctrl.idex_flush  = 1'b1;
                ctrl.exmem_flush = 1'b1;
                ctrl.memwb_wen   = 1'b1;
                if (dcnt_q == DRAIN_LIM) begin
                    state_d  = ST_HALTED;
                    dcnt_d   = 3'd0;
                    halted_d = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + 3'd1;
                end
            end

            ST_HALTED: begin
                halted_d = 1'b1;
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase

        // The flag rises on the edge where the wait count reaches the limit, so
        // it is visible in the same cycle the counter shows MEM_TIMEOUT.
        if (dfreeze && (tcnt_d == TIMEOUT_LIM)) begin
            mem_err_d = 1'b1;
        end

        // Reset forces every stage to a bubble and stops the PC, whatever
        // the state machine is in the middle of.
        if (RST) begin
            ctrl             = '0;
            ctrl.ifid_flush  = 1'b1;
            ctrl.idex_flush  = 1'b1;
            ctrl.exmem_flush = 1'b1;
            ctrl.memwb_flush = 1'b1;
            dfreeze          = 1'b0;
            branch_sq        = 1'b0;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_RUN;
            tcnt_q    <= 8'd0;
            dcnt_q    <= 3'd0;
            halted_q  <= 1'b0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tcnt_q    <= tcnt_d;
            dcnt_q    <= dcnt_d;
            halted_q  <= halted_d;
            mem_err_q <= mem_err_d;
        end
    end

    assign hz.pc_wen      = ctrl.pc_wen;
    assign hz.ifid_wen    = ctrl.ifid_wen;
    assign hz.ifid_flush  = ctrl.ifid_flush;
    assign hz.idex_wen    = ctrl.idex_wen;
    assign hz.idex_flush  = ctrl.idex_flush;
    assign hz.exmem_wen   = ctrl.exmem_wen;
    assign hz.exmem_flush = ctrl.exmem_flush;
    assign hz.memwb_wen   = ctrl.memwb_wen;
    assign hz.memwb_flush = ctrl.memwb_flush;
    // Sticky flags read as 0 for the whole reset cycle, not just after the edge.
    assign hz.halted      = halted_q  & ~RST;
    assign hz.mem_err     = mem_err_q & ~RST;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;
    logic        stall_evt;

    // Counts PC-stall cycles only while the pipe is live; DRAIN and HALTED
    // are not stalls, and both counters freeze once halted.
    assign stall_evt = ((state_q == ST_RUN) || (state_q == ST_DWAIT)) && !ctrl.pc_wen;

    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (stall_evt) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (branch_sq) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign hz.stall_cnt = stall_cnt_q;
    assign hz.flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Directed bench for pipe_hazard_ctrl with DRAIN_CYCLES=2 and MEM_TIMEOUT=4.
// Inputs change 2 time units after a rising edge; outputs are compared one
// unit later, well clear of the next edge. Expected control words are written
// out by hand in the order
//   {pc, ifid_wen, ifid_flush, idex_wen, idex_flush,
//    exmem_wen, exmem_flush, memwb_wen, memwb_flush, halted, mem_err}.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    logic CLK;
    logic RST;
    int   checks = 0;
    int   errors = 0;

    pipe_hazard_ctrl_if hz ();

    pipe_hazard_ctrl #(
        .DRAIN_CYCLES (2),
        .MEM_TIMEOUT  (4)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .hz  (hz)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    //                                   p if  id  ex  mw  h e
    localparam logic [10:0] P_RST = 11'b0_01_01_01_01_0_0;
    localparam logic [10:0] P_RUN = 11'b1_10_10_10_10_0_0;
    localparam logic [10:0] P_FRZ = 11'b0_00_00_00_00_0_0;
    localparam logic [10:0] P_HLT = 11'b0_01_01_01_10_0_0;   // halt issue and DRAIN
    localparam logic [10:0] P_BR  = 11'b1_01_01_01_10_0_0;
    localparam logic [10:0] P_LU  = 11'b0_00_01_10_10_0_0;
    localparam logic [10:0] P_NI  = 11'b0_01_10_10_10_0_0;
    localparam logic [10:0] P_STP = 11'b0_00_00_00_00_1_0;   // HALTED
    localparam logic [10:0] ERR   = 11'b0_00_00_00_00_0_1;

    logic [10:0] obs;
    assign obs = {hz.pc_wen, hz.ifid_wen, hz.ifid_flush, hz.idex_wen, hz.idex_flush,
                  hz.exmem_wen, hz.exmem_flush, hz.memwb_wen, hz.memwb_flush,
                  hz.halted, hz.mem_err};

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic check(input string tag, input logic [10:0] exp);
        #1;
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        hz.ihit         = 1'b1;
        hz.dmem_req     = 1'b0;
        hz.dhit         = 1'b0;
        hz.idex_memread = 1'b0;
        hz.idex_rt      = 5'd0;
        hz.ifid_rs      = 5'd0;
        hz.ifid_rt      = 5'd0;
        hz.branch_taken = 1'b0;
        hz.halt_mem     = 1'b0;
    endtask

    initial begin
        // Reset for two cycles, then normal flow.
        RST = 1'b1;
        clear_inputs();
        check("rst_c1", P_RST);
        step(); check("rst_c2", P_RST);
        step(); RST = 1'b0; check("post_rst_run", P_RUN);

        // Load-use hazards.
        step(); hz.idex_memread = 1'b1; hz.idex_rt = 5'd5; hz.ifid_rs = 5'd5;
        check("lu_rs", P_LU);
        step(); hz.ifid_rs = 5'd0; hz.ifid_rt = 5'd5;
        check("lu_rt", P_LU);
        step(); hz.idex_rt = 5'd0; hz.ifid_rt = 5'd0;
        check("lu_rt_zero", P_RUN);
        step(); hz.idex_rt = 5'd7; hz.ifid_rs = 5'd7; hz.ihit = 1'b0;
        check("lu_over_imiss", P_LU);
        step(); hz.idex_memread = 1'b0;
        check("imiss", P_NI);
        step(); hz.ihit = 1'b1;
        check("match_no_load", P_RUN);

        // Data wait: three frozen cycles, then release.
        step(); clear_inputs(); hz.dmem_req = 1'b1;
        check("dw_c1", P_FRZ);
        step(); check("dw_c2", P_FRZ);
        step(); check("dw_c3", P_FRZ);
        step(); hz.dhit = 1'b1;
        check("dw_release", P_RUN);
        step(); hz.dmem_req = 1'b0; hz.dhit = 1'b0;
        check("dw_back_in_run", P_RUN);

        // Data wait timeout: mem_err shows once the wait count reaches 4.
        step(); hz.dmem_req = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("to_c%0d", i), P_FRZ);
            step();
        end
        check("to_c5_err", P_FRZ | ERR);
        step(); hz.dhit = 1'b1;
        check("to_release", P_RUN | ERR);
        step(); hz.dmem_req = 1'b0; hz.dhit = 1'b0;
        check("to_err_sticky", P_RUN | ERR);

        // Reset clears mem_err, including in the reset cycle itself.
        step(); RST = 1'b1;
        check("rst_hides_err", P_RST);
        step(); RST = 1'b0;
        check("rst_err_cleared", P_RUN);

        // Reset in the second DWAIT cycle.
        step(); hz.dmem_req = 1'b1;
        check("rdw_c1", P_FRZ);
        step(); check("rdw_c2", P_FRZ);
        RST = 1'b1;
        check("rdw_rst", P_RST);
        step(); RST = 1'b0; hz.dmem_req = 1'b0;
        check("rdw_no_freeze", P_RUN);
        step(); hz.dmem_req = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            check($sformatf("rdw_stall_c%0d", i), P_FRZ);
            step();
        end
        hz.dhit = 1'b1;
        check("rdw_release_no_err", P_RUN);

        // Branch outranks load-use and fetch miss.
        step(); clear_inputs();
        hz.branch_taken = 1'b1; hz.idex_memread = 1'b1;
        hz.idex_rt = 5'd5; hz.ifid_rs = 5'd5; hz.ihit = 1'b0;
`ifdef HAZARD_PERF_EN
        #1;
        checks++;
        assert (hz.flush_cnt === 32'd0) else begin
            errors++;
            $error("FAIL flush_cnt_before: got %0d expected 0", hz.flush_cnt);
        end
`endif
        check("br_prio", P_BR);
        step(); clear_inputs();
`ifdef HAZARD_PERF_EN
        #1;
        checks++;
        assert (hz.flush_cnt === 32'd1) else begin
            errors++;
            $error("FAIL flush_cnt_after: got %0d expected 1", hz.flush_cnt);
        end
`endif
        check("br_done", P_RUN);

        // Branch resolved on the cycle a data wait releases.
        step(); hz.dmem_req = 1'b1;
        check("dwbr_frz", P_FRZ);
        step(); hz.dhit = 1'b1; hz.branch_taken = 1'b1;
        check("dwbr_branch", P_BR);

        // Halt outranks branch, then two DRAIN cycles, then HALTED.
        step(); clear_inputs(); hz.halt_mem = 1'b1; hz.branch_taken = 1'b1;
        check("halt_prio", P_HLT);
        step(); hz.halt_mem = 1'b0; hz.dmem_req = 1'b1; hz.dhit = 1'b0;
        check("drain_c1", P_HLT);
        step(); check("drain_c2", P_HLT);
        step();
        for (int i = 1; i <= 10; i++) begin
            check($sformatf("halted_c%0d", i), P_STP);
            step();
        end
        RST = 1'b1;
        check("halted_rst", P_RST);
        step(); RST = 1'b0; clear_inputs();
        check("halted_rst_run", P_RUN);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
